// File: rtl/double_pkg.sv
// ============================================================================
// Module   : double_pkg
// Purpose  : Shared binary64 field layout, integer limits and the
//            double_to_long state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package double_pkg;

  localparam int unsigned DBL_BIAS     = 1023;
  localparam int unsigned DBL_EXP_MAX  = 2047;

  localparam int unsigned DBL_SIGN_BIT = 63;
  localparam int unsigned DBL_EXP_MSB  = 62;
  localparam int unsigned DBL_EXP_LSB  = 52;
  localparam int unsigned DBL_FRAC_MSB = 51;

  localparam logic [63:0] LONG_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] LONG_MAX = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef enum logic [3:0] {
    S_GET_A         = 4'd0,
    S_UNPACK        = 4'd1,
    S_SPECIAL_CASES = 4'd2,
    S_CONVERT       = 4'd3,
    S_NEGATE        = 4'd4,
    S_PUT_Z         = 4'd5
  } d2l_state_t;

endpackage

`default_nettype wire

// File: rtl/double_to_long.sv
// ============================================================================
// Module   : double_to_long
// Purpose  : binary64 -> signed 64-bit integer, round toward zero, stb/ack
//            handshake. Define DOUBLE_TO_LONG_SATURATE_EN for saturating
//            NaN/overflow results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module double_to_long
  import double_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  d2l_state_t         r_state, w_state_nxt;
  logic [63:0]        r_a, w_a_nxt;
  logic [63:0]        r_m, w_m_nxt;
  logic signed [12:0] r_e, w_e_nxt;
  logic               r_s, w_s_nxt;
  logic [63:0]        r_z, w_z_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_stb, w_stb_nxt;
  logic [63:0]        r_out, w_out_nxt;

  logic [10:0]        w_exp;
  logic [51:0]        w_frac;
  logic               w_is_nan;
  logic [63:0]        w_nan_z;
  logic [63:0]        w_ovf_z;

  assign w_exp    = r_a[DBL_EXP_MSB:DBL_EXP_LSB];
  assign w_frac   = r_a[DBL_FRAC_MSB:0];
  assign w_is_nan = (w_exp == 11'(DBL_EXP_MAX)) && (w_frac != 52'd0);

`ifdef DOUBLE_TO_LONG_SATURATE_EN
  assign w_nan_z = 64'd0;
  assign w_ovf_z = r_a[DBL_SIGN_BIT] ? LONG_MIN : LONG_MAX;
`else
  assign w_nan_z = LONG_MIN;
  assign w_ovf_z = LONG_MIN;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_m_nxt     = r_m;
    w_e_nxt     = r_e;
    w_s_nxt     = r_s;
    w_z_nxt     = r_z;
    w_ack_nxt   = r_ack;
    w_stb_nxt   = r_stb;
    w_out_nxt   = r_out;

    case (r_state)
      S_GET_A: begin
        w_ack_nxt = 1'b1;
        if (r_ack && input_a_stb) begin
          w_a_nxt     = input_a;
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_UNPACK;
        end
      end

      S_UNPACK: begin
        w_m_nxt     = {1'b1, r_a[DBL_FRAC_MSB:0], 11'b0};
        w_e_nxt     = $signed({2'b00, w_exp} - 13'(DBL_BIAS));
        w_s_nxt     = r_a[DBL_SIGN_BIT];
        w_state_nxt = S_SPECIAL_CASES;
      end

      // Infinity has e = 1024, so it falls into the overflow branch.
      S_SPECIAL_CASES: begin
        if (w_is_nan) begin
          w_z_nxt     = w_nan_z;
          w_state_nxt = S_PUT_Z;
        end else if (r_e >= 13'sd63) begin
          w_z_nxt     = w_ovf_z;
          w_state_nxt = S_PUT_Z;
        end else if (r_e < 13'sd0) begin
          w_z_nxt     = 64'd0;
          w_state_nxt = S_PUT_Z;
        end else begin
          w_state_nxt = S_CONVERT;
        end
      end

      S_CONVERT: begin
        if (r_e < 13'sd63) begin
          w_m_nxt = r_m >> 1;
          w_e_nxt = r_e + 13'sd1;
        end else begin
          w_state_nxt = S_NEGATE;
        end
      end

      S_NEGATE: begin
        w_z_nxt     = r_s ? (~r_m + 64'd1) : r_m;
        w_state_nxt = S_PUT_Z;
      end

      S_PUT_Z: begin
        w_stb_nxt = 1'b1;
        w_out_nxt = r_z;
        if (r_stb && output_z_ack) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_GET_A;
        end
      end

      default: begin
        w_state_nxt = S_GET_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GET_A;
      r_a     <= 64'd0;
      r_m     <= 64'd0;
      r_e     <= 13'sd0;
      r_s     <= 1'b0;
      r_z     <= 64'd0;
      r_ack   <= 1'b0;
      r_stb   <= 1'b0;
      r_out   <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_m     <= w_m_nxt;
      r_e     <= w_e_nxt;
      r_s     <= w_s_nxt;
      r_z     <= w_z_nxt;
      r_ack   <= w_ack_nxt;
      r_stb   <= w_stb_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign input_a_ack  = r_ack;
  assign output_z_stb = r_stb;
  assign output_z     = r_out;

endmodule

`default_nettype wire

// File: tb/tb_double_to_long.sv
// ============================================================================
// Module   : tb_double_to_long
// Purpose  : Directed-vector bench for double_to_long (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_double_to_long;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] input_a = 64'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DOUBLE_TO_LONG_SATURATE_EN
  localparam logic [63:0] c_pos_ovf = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_nan     = 64'h0000_0000_0000_0000;
`else
  localparam logic [63:0] c_pos_ovf = 64'h8000_0000_0000_0000;
  localparam logic [63:0] c_nan     = 64'h8000_0000_0000_0000;
`endif

  always #5 clk = ~clk;

  double_to_long dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // Offer an operand, wait for capture; returns 0 if it was never accepted.
  task automatic send(input logic [63:0] a, output bit ok);
    int t;
    ok = 1'b0;
    @(negedge clk);
    input_a     = a;
    input_a_stb = 1'b1;
    for (t = 0; t < 50; t++) begin
      if (input_a_ack) break;
      @(negedge clk);
    end
    if (t == 50) begin
      check("accept_timeout", 64'd1, 64'd0);
      input_a_stb = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    ok = 1'b1;
  endtask

  // Full conversion: capture, measured latency, result value, release.
  task automatic run(input string tag, input logic [63:0] a,
                     input logic [63:0] exp_z, input int exp_lat);
    bit ok;
    int lat;
    send(a, ok);
    if (!ok) return;
    // Capture edge was the posedge before the current negedge; that
    // posedge is N, so the edge after it is N+1.
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (output_z_stb) break;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_z"}, output_z, exp_z);
    @(negedge clk);
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    check({tag, "_stb_clr"}, {63'd0, output_z_stb}, 64'd0);
  endtask

  initial begin : main
    bit ok;
    logic [63:0] held;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {63'd0, input_a_ack}, 64'd0);
    check("rst_stb", {63'd0, output_z_stb}, 64'd0);
    check("rst_z",   output_z, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("one",      64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 68);
    run("m2p5",     64'hC004_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 67);
    run("hundred",  64'h4059_0000_0000_0000, 64'h0000_0000_0000_0064, 62);
    run("p0p75",    64'h3FE8_0000_0000_0000, 64'h0, 3);
    run("negzero",  64'h8000_0000_0000_0000, 64'h0, 3);
    run("denorm",   64'h0000_0000_0000_0001, 64'h0, 3);
    run("p2e62",    64'h43D0_0000_0000_0000, 64'h4000_0000_0000_0000, 6);
    run("m2e62",    64'hC3D0_0000_0000_0000, 64'hC000_0000_0000_0000, 6);
    run("p2e63",    64'h43E0_0000_0000_0000, c_pos_ovf, 3);
    run("m2e63",    64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 3);
    run("pinf",     64'h7FF0_0000_0000_0000, c_pos_ovf, 3);
    run("minf",     64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 3);
    run("nan",      64'h7FF8_0000_0000_0000, c_nan, 3);

    // Backpressure: result must hold while ack is withheld.
    send(64'h4059_0000_0000_0000, ok);
    if (ok) begin
      repeat (70) @(posedge clk);
      #1;
      check("bp_stb_up", {63'd0, output_z_stb}, 64'd1);
      held = output_z;
      check("bp_value", held, 64'h64);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        check("bp_stb_hold", {63'd0, output_z_stb}, 64'd1);
        check("bp_z_hold", output_z, 64'h64);
      end
      @(negedge clk);
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      check("bp_stb_drop", {63'd0, output_z_stb}, 64'd0);
      repeat (5) @(posedge clk);
      #1;
      check("bp_single", {63'd0, output_z_stb}, 64'd0);
    end

    // Reset in the middle of the shift loop.
    send(64'h3FF0_0000_0000_0000, ok);
    if (ok) begin
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_ack", {63'd0, input_a_ack}, 64'd0);
      check("mid_rst_stb", {63'd0, output_z_stb}, 64'd0);
      check("mid_rst_z",   output_z, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      check("mid_rst_noresult", {63'd0, output_z_stb}, 64'd0);
      run("post_rst", 64'h4000_0000_0000_0000, 64'h2, 67);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
